hmux8way_rr: RTL and testbench
==============================

Name: hmux8way_rr

Overview:
- 8-to-1 gathering multiplexer: merges eight independent WIDTH-bit producer channels onto one consumer stream. It is the collecting counterpart of the hDMux8Way distribution path.
- Fair round-robin arbitration with valid/ready handshakes on every channel.
- One registered output stage, so the consumer sees glitch-free registered data and a registered source index.
- Used where several Hack-side sources (e.g. peripheral word producers) share one downstream sink.

Parameters:
WIDTH, 16, data word width per channel (Hack word)

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  8  per-channel request; bit i = channel i holds a word
in_data  input  8*WIDTH  channel i word at bits [i*WIDTH +: WIDTH]
in_ready  output  8  per-channel accept; at most one bit high (one-hot or zero)
out_valid  output  1  output register holds a word
out_data  output  WIDTH  registered word
out_sel  output  3  registered index of the channel that supplied out_data
out_ready  input  1  consumer accepts out_data this cycle

Behaviour:
- Reset (async, active-high, level-held): out_valid=0, out_data=0, out_sel=0, round-robin pointer ptr=0. While reset is high, in_ready=0.
- A transfer in is in_valid[i] & in_ready[i] at a clk edge. A transfer out is out_valid & out_ready at a clk edge.
- load_en = !out_valid | out_ready. The output register can take a new word this cycle.
- Arbitration (combinational):
  - Scan channels ptr, ptr+1, …, ptr+7, mod 8 wrap.
  - grant = first index with in_valid set.
  - in_ready[grant] = load_en. All other in_ready bits are 0.
  - If no in_valid bit is set, in_ready = 0.
- in_ready depends combinationally on in_valid, ptr and out_ready. Producers must not make in_valid depend on in_ready.
- On a clk edge with load_en and any request:
  - out_data ← in_data[grant]
  - out_sel ← grant
  - out_valid ← 1
  - ptr ← (grant+1) mod 8
- On a clk edge with load_en and no request:
  - out_valid ← 0 (drains on transfer out)
  - out_data, out_sel, ptr hold their values.
- On a clk edge with !load_en (out_valid=1, out_ready=0):
  - out_data, out_sel, out_valid, ptr all hold. No input is accepted.
- Simultaneous drain and refill (out_valid=1, out_ready=1, request present): the new word loads in the same edge. Throughput is 1 word/cycle with no bubble.
- Latency: 1 cycle from input acceptance to out_valid.
- Fairness: a channel holding in_valid continuously is granted within 8 load_en cycles.
- ptr advances only on a grant. Idle cycles do not rotate priority.
- Wrap-around: grant=7 sets ptr=0.
- Reset mid-operation: an in-flight output word is discarded. A producer whose handshake coincides with the reset assertion is not considered transferred.
- out_data may hold stale values while out_valid=0. The consumer ignores it.
- No X propagation: all registers have reset values.

Test Plan:
- Reset then all in_valid=8'hFF, in_data[i]=16'h1000+i, out_ready=1 held. Required: out_sel sequence 0,1,…,7,0,… one per cycle from the first cycle after reset release; out_data=16'h1000+out_sel; exactly one in_ready bit high per cycle.
- Backpressure: out_valid=1 with out_sel=3, out_data=16'h1003; drive out_ready=0 for 5 cycles with channels 4 and 5 valid. Required: in_ready=0 and out_data/out_sel stable for all 5 cycles. Then out_ready=1: next word is from channel 4, then channel 5.
- Wrap: force ptr=7 via a prior grant of channel 6; then only channels 2 and 6 valid. Required: grant 2 first (scan order 7,0,1,2), then 6, then 2.
- Sparse/idle: single request on channel 5 for one cycle, then none. Required: out_valid=1, out_sel=5 for one cycle, then out_valid=0; ptr stays 6 through 10 idle cycles; next request on channel 6 wins over channel 0 when both are raised together.
- Reset mid-stream: assert reset asynchronously between edges while out_valid=1 and 8'hFF requests are present. Required: out_valid, out_data, out_sel drop to 0 immediately; in_ready=0 during reset; after release, first grant is channel 0.
- Fairness soak: random in_valid and out_ready for 10,000 cycles with a scoreboard. Required: no lost or duplicated words, per-channel order preserved, no channel waits more than 8 load_en cycles.

Source files
------------

// File: rtl/hmux8way_rr.sv
// Eight-channel gathering mux: fair round-robin arbitration over valid/ready
// producers into a single registered output stage.
module hmux8way_rr #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           in_valid,
  input  logic [8*WIDTH-1:0]   in_data,
  output logic [7:0]           in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [2:0]           out_sel,
  input  logic                 out_ready
);

  logic [2:0]       ptr;
  logic             vld_p0;
  logic [WIDTH-1:0] data_p0;
  logic [2:0]       sel_p0;
  logic [2:0]       grant;
  logic             any_req;
  logic             load_en;

  // Returns {found, index} of the first requester at or after base, wrapping mod 8.
  // Scanning from the far end lets the nearest requester overwrite the result.
  function automatic logic [3:0] pick(input logic [7:0] req, input logic [2:0] base);
    logic [3:0] res;
    logic [2:0] idx;
    res = '0;
    for (int k = 7; k >= 0; k--) begin
      idx = base + 3'(k);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_comb begin
    {any_req, grant} = pick(in_valid, ptr);
  end

  assign load_en = !vld_p0 || out_ready;

  always_comb begin
    in_ready = '0;
    if (!reset && any_req && load_en) in_ready[grant] = 1'b1;
  end

  // Output stage p0: capture the granted word; priority rotates only on a grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p0  <= 1'b0;
      data_p0 <= '0;
      sel_p0  <= '0;
      ptr     <= '0;
    end else if (load_en) begin
      if (any_req) begin
        vld_p0  <= 1'b1;
        data_p0 <= in_data[int'(grant)*WIDTH +: WIDTH];
        sel_p0  <= grant;
        ptr     <= grant + 3'd1;
      end else begin
        vld_p0  <= 1'b0;
      end
    end
  end

  assign out_valid = vld_p0;
  assign out_data  = data_p0;
  assign out_sel   = sel_p0;

endmodule

// File: tb/tb_hmux8way_rr.sv
// Bench for hmux8way_rr: directed vector table, reset corner case and a
// randomized soak against a reference arbiter model with per-channel scoreboard.
module tb_hmux8way_rr;

  logic         clk;
  logic         reset;
  logic [7:0]   in_valid;
  logic [127:0] in_data;
  logic [7:0]   in_ready;
  logic         out_valid;
  logic [15:0]  out_data;
  logic [2:0]   out_sel;
  logic         out_ready;

  hmux8way_rr #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  valid;
    logic        rdy;
    logic [7:0]  exp_ready;
    logic        exp_vld;
    logic [2:0]  exp_sel;
    logic [15:0] exp_data;
  } vec_t;

  vec_t vecs[$];
  int   errors;
  int   checks;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [7:0] v, input logic r, input logic [7:0] er,
                     input logic ev, input logic [2:0] es, input logic [15:0] ed);
    vec_t t;
    t.valid = v; t.rdy = r; t.exp_ready = er;
    t.exp_vld = ev; t.exp_sel = es; t.exp_data = ed;
    vecs.push_back(t);
  endtask

  // soak model state
  logic [2:0]  m_ptr, m_sel, m_gnt, idx;
  logic        m_vld, m_load, m_any;
  logic [15:0] m_data;
  logic [7:0]  exp_rdy;
  int          seq_in[8], seq_out[8], waitc[8];
  int          pend;

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b1;
    in_valid = 8'hFF;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) in_data[i*16 +: 16] = 16'h1000 + 16'(i);

    // round-robin sweep with all channels requesting
    for (int k = 0; k < 9; k++)
      add(8'hFF, 1'b1, 8'(1) << (k % 8), 1'b1, 3'(k % 8), 16'h1000 + 16'(k % 8));
    add(8'h08, 1'b1, 8'h08, 1'b1, 3'd3, 16'h1003);
    for (int k = 0; k < 5; k++) add(8'h30, 1'b0, 8'h00, 1'b1, 3'd3, 16'h1003);
    add(8'h30, 1'b1, 8'h10, 1'b1, 3'd4, 16'h1004);
    add(8'h30, 1'b1, 8'h20, 1'b1, 3'd5, 16'h1005);
    add(8'h40, 1'b1, 8'h40, 1'b1, 3'd6, 16'h1006);
    add(8'h44, 1'b1, 8'h04, 1'b1, 3'd2, 16'h1002);
    add(8'h44, 1'b1, 8'h40, 1'b1, 3'd6, 16'h1006);
    add(8'h44, 1'b1, 8'h04, 1'b1, 3'd2, 16'h1002);
    add(8'h20, 1'b1, 8'h20, 1'b1, 3'd5, 16'h1005);
    for (int k = 0; k < 11; k++) add(8'h00, 1'b1, 8'h00, 1'b0, 3'd5, 16'h1005);
    add(8'h41, 1'b1, 8'h40, 1'b1, 3'd6, 16'h1006);
    add(8'h00, 1'b1, 8'h00, 1'b0, 3'd6, 16'h1006);
    add(8'h01, 1'b0, 8'h01, 1'b1, 3'd0, 16'h1000);
    add(8'h02, 1'b0, 8'h00, 1'b1, 3'd0, 16'h1000);
    add(8'h00, 1'b1, 8'h00, 1'b0, 3'd0, 16'h1000);

    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_sel", 32'(out_sel), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      in_valid = vecs[i].valid;
      out_ready = vecs[i].rdy;
      #1;
      chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].exp_ready));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].exp_vld));
      chk($sformatf("vec%0d_out_sel", i), 32'(out_sel), 32'(vecs[i].exp_sel));
      chk($sformatf("vec%0d_out_data", i), 32'(out_data), 32'(vecs[i].exp_data));
      @(negedge clk);
    end

    // reset asserted between edges with a word in flight (ptr is 1 here)
    in_valid = 8'hFF;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_pre_sel", 32'(out_sel), 32'd1);
    chk("mid_pre_valid", 32'(out_valid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_data", 32'(out_data), 32'd0);
    chk("mid_rst_sel", 32'(out_sel), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("mid_hold_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_rel_in_ready", 32'(in_ready), 32'h01);
    @(posedge clk);
    #1;
    chk("mid_rel_sel", 32'(out_sel), 32'd0);
    chk("mid_rel_valid", 32'(out_valid), 32'd1);

    // soak: restart from reset with the model
    @(negedge clk);
    in_valid = 8'h00;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_ptr = '0; m_sel = '0; m_vld = 1'b0; m_data = '0;
    for (int i = 0; i < 8; i++) begin seq_in[i] = 0; seq_out[i] = 0; waitc[i] = 0; end

    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < 8; i++)
        if (!in_valid[i] && $urandom_range(0, 1) == 1) begin
          in_valid[i] = 1'b1;
          in_data[i*16 +: 16] = {3'(i), 13'(seq_in[i])};
        end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      m_load = !m_vld || out_ready;
      m_any = 1'b0;
      m_gnt = '0;
      for (int k = 0; k < 8; k++) begin
        idx = m_ptr + 3'(k);
        if (!m_any && in_valid[idx]) begin m_any = 1'b1; m_gnt = idx; end
      end
      exp_rdy = (m_load && m_any) ? (8'(1) << m_gnt) : 8'h00;
      chk("soak_in_ready", 32'(in_ready), 32'(exp_rdy));
      if (m_vld && out_ready) begin
        chk("soak_order", 32'(out_data), 32'({m_sel, 13'(seq_out[m_sel])}));
        seq_out[m_sel]++;
      end
      for (int i = 0; i < 8; i++)
        if (m_load && in_valid[i]) begin
          if (m_any && m_gnt == 3'(i)) begin
            chk("soak_fair", 32'(waitc[i] <= 7), 32'd1);
            waitc[i] = 0;
          end else begin
            waitc[i]++;
          end
        end
      if (m_load) begin
        if (m_any) begin
          m_vld = 1'b1;
          m_sel = m_gnt;
          m_data = in_data[int'(m_gnt)*16 +: 16];
          m_ptr = m_gnt + 3'd1;
          seq_in[m_gnt]++;
        end else begin
          m_vld = 1'b0;
        end
      end
      @(posedge clk);
      #1;
      if (m_load && m_any) in_valid[m_gnt] = 1'b0;
      chk("soak_out_valid", 32'(out_valid), 32'(m_vld));
      if (m_vld) begin
        chk("soak_out_sel", 32'(out_sel), 32'(m_sel));
        chk("soak_out_data", 32'(out_data), 32'(m_data));
      end
    end

    for (int i = 0; i < 8; i++) begin
      pend = (m_vld && m_sel == 3'(i)) ? 1 : 0;
      chk($sformatf("soak_count_ch%0d", i), 32'(seq_out[i] + pend), 32'(seq_in[i]));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
